territory_tally: RTL and testbench
==================================

Name: territory_tally

Overview:
- Runs once at game end; the datapath sweeps this block's results onto the score screen.
- Sweeps the 160x120 ownership RAM once, which is addressed as {x[7:0], y[6:0]}.
- Counts the pixels owned by each of the four players and ranks the players by count.
- Outputs the 12-bit ordered_colours word that the end-screen number renderer consumes.
- Sits between the 3-bit ownership RAM read port and the datapath's end-screen drawing states.

Parameters:
- X_MAX, 160, number of columns swept (x = 0..X_MAX-1).
- Y_MAX, 120, number of rows swept (y = 0..Y_MAX-1).
- RAM_LATENCY, 1, cycles from ram_address to valid ram_q (synchronous RAM).
- P1_COLOUR, 3'b001, ownership code of player 1.
- P2_COLOUR, 3'b010, ownership code of player 2.
- P3_COLOUR, 3'b100, ownership code of player 3.
- P4_COLOUR, 3'b110, ownership code of player 4.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a tally; honoured only in IDLE or DONE.
- ram_q  in  3  RAM read data for the address issued RAM_LATENCY cycles earlier.
- ram_address  out  15  {x[7:0], y[6:0]} read address.
- p1_count  out  15  pixels owned by player 1; same meaning for p2_count, p3_count, p4_count (each out, 15 bits).
- ordered_colours  out  12  [11:9] is the rank-1 colour (highest count), then [8:6], [5:3], [2:0] for ranks 2 to 4.
- busy  out  1  high in SWEEP, DRAIN and SORT.
- done  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state = IDLE; ram_address, all counts, busy and done = 0.
  - ordered_colours = {P1,P2,P3,P4}_COLOUR, i.e. 12'b001_010_100_110.
  - All pipeline valid bits are cleared.
  - Reset mid-operation abandons the sweep immediately; no partial results are kept.
- States: IDLE, SWEEP, DRAIN, SORT, DONE.
- IDLE / DONE:
  - ram_address = 0; counts and ordered_colours hold their values.
  - start=1 at edge E0: clear all four counts, set x=y=0, enter SWEEP.
- SWEEP:
  - Each cycle, present ram_address={x,y}, then advance. y increments first; at y=Y_MAX-1, y wraps to 0 and x increments.
  - After the address {X_MAX-1, Y_MAX-1} is issued, enter DRAIN. SWEEP lasts exactly X_MAX*Y_MAX = 19200 cycles.
  - A RAM_LATENCY-deep valid shift register tracks issued reads.
  - When a valid ram_q matches a P*_COLOUR, that player's count increments by 1.
  - Any other code (000 background, 111 timer bar, unused codes) is ignored.
  - Counts cannot overflow (19200 < 32768); no saturation logic.
- DRAIN: lasts RAM_LATENCY cycles so the last reads are counted, then enter SORT.
- SORT: exactly 5 cycles, one compare-swap per cycle on the slots (0,1), (2,3), (0,2), (1,3), (1,2).
  - Slots initially hold players 1-4.
  - Sort key = {count, 2'd3 - player_index}, so ties rank the lower player index first.
  - Swap when key(b) > key(a), giving a descending order.
  - On exit, register ordered_colours from the slot colours and enter DONE.
- Latency: done rises at edge E0 + 19205 + RAM_LATENCY (19206 with the default). busy covers every cycle from E0+1 until then.
- start while busy is ignored.
- start in DONE restarts the tally: done drops at the next edge.
- ordered_colours is updated only on SORT exit, so it never shows a partial result while busy.

Test Plan:
- All-zero RAM, start pulse -> all counts 0, ordered_colours=12'b001_010_100_110; done exactly 19206 cycles after start.
- RAM with P3 owning 100 pixels, P1 50, P4 30, P2 10, plus the timer row of 111 -> counts 50/10/100/30; ordered_colours=100_001_110_010.
- P2=P4=200, P1=P3=5 -> ordered_colours=010_110_001_100 (tie broken by lower index).
- Pulse start at cycles 10 and 5000 of a sweep -> ignored; done timing unchanged; counts match a single sweep.
- Deassert resetn at cycle 8000 of a sweep -> outputs return to reset values immediately; a fresh start yields correct counts.
- After done, change the RAM contents and pulse start -> done drops next cycle, busy rises; new counts and ranking replace the old ones only at the new done.

Source files
------------

// File: rtl/territory_tally_if.sv
// Connection bundle between the territory tally block and the end-screen
// datapath. The datapath (master) issues the start pulse and returns the
// ownership RAM read data. The tally block (slave) drives the read address,
// the per-player counts, the ranking and the status flags.
interface territory_tally_if;
    logic        start;
    logic [2:0]  ram_q;
    logic [14:0] ram_address;
    logic [14:0] p1_count;
    logic [14:0] p2_count;
    logic [14:0] p3_count;
    logic [14:0] p4_count;
    logic [11:0] ordered_colours;
    logic        busy;
    logic        done;

    modport master (
        output start, ram_q,
        input  ram_address, p1_count, p2_count, p3_count, p4_count,
               ordered_colours, busy, done
    );

    modport slave (
        input  start, ram_q,
        output ram_address, p1_count, p2_count, p3_count, p4_count,
               ordered_colours, busy, done
    );
endinterface

// File: rtl/territory_tally.sv
// End-of-game territory tally. Sweeps the 160x120 ownership RAM once, counts
// the pixels owned by each player, then ranks the players with a 5-step
// compare-swap network. The packed ranking feeds the score-screen renderer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start after reset; address parked at 0
// SWEEP | one RAM read issued per cycle, y fastest, x slowest
// DRAIN | waiting for the last RAM_LATENCY reads to come back and be counted
// SORT  | five compare-swap steps, one per cycle, on the four player slots
// DONE  | results stable; start launches a fresh tally
module territory_tally #(
    parameter int          X_MAX       = 160,
    parameter int          Y_MAX       = 120,
    parameter int          RAM_LATENCY = 1,
    parameter logic [2:0]  P1_COLOUR   = 3'b001,
    parameter logic [2:0]  P2_COLOUR   = 3'b010,
    parameter logic [2:0]  P3_COLOUR   = 3'b100,
    parameter logic [2:0]  P4_COLOUR   = 3'b110
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    territory_tally_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, SORT, DONE} state_t;

    localparam logic [7:0]  X_LAST      = 8'(X_MAX - 1);
    localparam logic [6:0]  Y_LAST      = 7'(Y_MAX - 1);
    localparam logic [7:0]  DRAIN_LOAD  = 8'(RAM_LATENCY - 1);
    localparam logic [11:0] RESET_ORDER = {P1_COLOUR, P2_COLOUR, P3_COLOUR, P4_COLOUR};

    state_t                   state;
    logic [7:0]               x;
    logic [6:0]               y;
    logic [7:0]               drain_left;
    logic [2:0]               sort_left;
    logic [RAM_LATENCY-1:0]   valid_sr;
    logic [14:0]              cnt [4];
    logic [1:0]               slot [4];
    logic [1:0]               slot_nxt [4];
    logic [16:0]              slot_key [4];
    logic [1:0]               pa;
    logic [1:0]               pb;
    logic                     issue;
    logic                     tally_clear;
    logic                     busy_r;
    logic                     done_r;
    logic [11:0]              order_r;

    function automatic logic [2:0] colour_of(input logic [1:0] idx);
        logic [2:0] c;
        c = P1_COLOUR;
        case (idx)
            2'd0: c = P1_COLOUR;
            2'd1: c = P2_COLOUR;
            2'd2: c = P3_COLOUR;
            2'd3: c = P4_COLOUR;
            default: c = P1_COLOUR;
        endcase
        return c;
    endfunction

    assign issue       = (state == SWEEP);
    assign tally_clear = bus.start && (state == IDLE || state == DONE);

    assign bus.ram_address     = {x, y};
    assign bus.p1_count        = cnt[0];
    assign bus.p2_count        = cnt[1];
    assign bus.p3_count        = cnt[2];
    assign bus.p4_count        = cnt[3];
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.ordered_colours = order_r;

    // Sort key per slot: count first, then inverted player index so that ties
    // favour the lower-numbered player. Keys read the live counts, which are
    // final by the first SORT edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_key[i] = {cnt[slot[i]], 2'd3 - slot[i]};
        end
    end

    // Pick this cycle's compare-swap pair and produce the post-swap slot order.
    always_comb begin
        pa = 2'd0;
        pb = 2'd1;
        case (sort_left)
            3'd4: begin pa = 2'd0; pb = 2'd1; end
            3'd3: begin pa = 2'd2; pb = 2'd3; end
            3'd2: begin pa = 2'd0; pb = 2'd2; end
            3'd1: begin pa = 2'd1; pb = 2'd3; end
            3'd0: begin pa = 2'd1; pb = 2'd2; end
            default: begin pa = 2'd0; pb = 2'd1; end
        endcase
        slot_nxt = slot;
        if (slot_key[pb] > slot_key[pa]) begin
            slot_nxt[pa] = slot[pb];
            slot_nxt[pb] = slot[pa];
        end
    end

    // Track issued reads through the RAM pipeline and count returning pixels.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            valid_sr <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            valid_sr <= RAM_LATENCY'({valid_sr, issue});
            if (tally_clear) begin
                for (int i = 0; i < 4; i++) cnt[i] <= '0;
            end else if (valid_sr[RAM_LATENCY-1]) begin
                case (bus.ram_q)
                    P1_COLOUR: cnt[0] <= cnt[0] + 15'd1;
                    P2_COLOUR: cnt[1] <= cnt[1] + 15'd1;
                    P3_COLOUR: cnt[2] <= cnt[2] + 15'd1;
                    P4_COLOUR: cnt[3] <= cnt[3] + 15'd1;
                    default: ;
                endcase
            end
        end
    end

    // Sequencing FSM: sweep addressing, drain timer, sort steps and status flags.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            drain_left <= '0;
            sort_left  <= '0;
            for (int i = 0; i < 4; i++) slot[i] <= 2'(i);
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            order_r    <= RESET_ORDER;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        x      <= '0;
                        y      <= '0;
                        state  <= SWEEP;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                SWEEP: begin
                    // Wrapping x back to 0 on the last address parks ram_address at 0.
                    if (y == Y_LAST) begin
                        y <= '0;
                        if (x == X_LAST) begin
                            x          <= '0;
                            state      <= DRAIN;
                            drain_left <= DRAIN_LOAD;
                        end else begin
                            x <= x + 8'd1;
                        end
                    end else begin
                        y <= y + 7'd1;
                    end
                end
                DRAIN: begin
                    if (drain_left == 8'd0) begin
                        state     <= SORT;
                        sort_left <= 3'd4;
                        for (int i = 0; i < 4; i++) slot[i] <= 2'(i);
                    end else begin
                        drain_left <= drain_left - 8'd1;
                    end
                end
                SORT: begin
                    slot <= slot_nxt;
                    if (sort_left == 3'd0) begin
                        order_r <= {colour_of(slot_nxt[0]), colour_of(slot_nxt[1]),
                                    colour_of(slot_nxt[2]), colour_of(slot_nxt[3])};
                        state   <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        sort_left <= sort_left - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_territory_tally.sv
// Directed bench for territory_tally: synchronous RAM model, hand-built
// ownership maps and hand-computed counts, rankings and latencies.
module tb_territory_tally;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    territory_tally_if bus();

    territory_tally dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus.slave)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [2:0] mem [0:32767];

    // One-cycle synchronous read port.
    always @(posedge CLOCK_50) bus.ram_q <= mem[bus.ram_address];

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] OC_RESET = 12'b001_010_100_110;
    localparam logic [11:0] OC_MIXED = 12'b100_001_110_010;
    localparam logic [11:0] OC_TIE   = 12'b010_110_001_100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 3'b000;
    endtask

    task automatic fill_row(input int x0, input int x1, input int yy, input logic [2:0] v);
        for (int xx = x0; xx <= x1; xx++) mem[{8'(xx), 7'(yy)}] = v;
    endtask

    // P3=100, P1=50, P4=30, P2=10 plus a timer bar of 111.
    task automatic load_mixed();
        clear_mem();
        fill_row(0, 99, 10, 3'b100);
        fill_row(0, 49, 20, 3'b001);
        fill_row(0, 29, 30, 3'b110);
        fill_row(0, 9, 40, 3'b010);
        fill_row(0, 159, 119, 3'b111);
    endtask

    // P2=P4=200, P1=P3=5, plus unused codes and a timer bar.
    task automatic load_tie();
        clear_mem();
        fill_row(0, 159, 50, 3'b010);
        fill_row(0, 39, 51, 3'b010);
        fill_row(0, 159, 60, 3'b110);
        fill_row(0, 39, 61, 3'b110);
        fill_row(0, 4, 70, 3'b001);
        fill_row(0, 4, 80, 3'b100);
        fill_row(0, 20, 90, 3'b011);
        fill_row(0, 20, 91, 3'b101);
        fill_row(0, 159, 119, 3'b111);
    endtask

    task automatic check_counts(input string tag, input int c1, input int c2, input int c3, input int c4);
        check({tag, "_p1"}, 32'(bus.p1_count), c1);
        check({tag, "_p2"}, 32'(bus.p2_count), c2);
        check({tag, "_p3"}, 32'(bus.p3_count), c3);
        check({tag, "_p4"}, 32'(bus.p4_count), c4);
    endtask

    // Pulse start, then step one cycle at a time until done (bounded).
    task automatic run_tally(input string tag, input bit extra_starts, input logic [11:0] old_oc);
        int n;
        @(posedge CLOCK_50); #1 bus.start = 1'b1;
        @(posedge CLOCK_50); #1 bus.start = 1'b0;
        check({tag, "_busy_e0"}, 32'(bus.busy), 1);
        check({tag, "_done_e0"}, 32'(bus.done), 0);
        check({tag, "_oc_e0"}, 32'(bus.ordered_colours), 32'(old_oc));
        n = 0;
        while (bus.done !== 1'b1 && n < 20000) begin
            @(posedge CLOCK_50); #1;
            n++;
            if (extra_starts) bus.start = (n == 10 || n == 5000);
            if (n == 5)   check({tag, "_addr5"}, 32'(bus.ram_address), 32'({8'd0, 7'd5}));
            if (n == 121) check({tag, "_addr121"}, 32'(bus.ram_address), 32'({8'd1, 7'd1}));
            if (n == 100) check({tag, "_oc_held"}, 32'(bus.ordered_colours), 32'(old_oc));
            if (n == 19205) check({tag, "_busy_last"}, 32'(bus.busy), 1);
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, n, 19206);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        check({tag, "_addr_end"}, 32'(bus.ram_address), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        clear_mem();
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_addr", 32'(bus.ram_address), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_oc", 32'(bus.ordered_colours), 32'(OC_RESET));
        check_counts("rst", 0, 0, 0, 0);
        resetn = 1'b1;

        // All-zero RAM.
        run_tally("zero", 1'b0, OC_RESET);
        check_counts("zero", 0, 0, 0, 0);
        check("zero_oc", 32'(bus.ordered_colours), 32'(OC_RESET));
        check("zero_done", 32'(bus.done), 1);

        // Reset part-way through a sweep of the mixed map.
        load_mixed();
        @(posedge CLOCK_50); #1 bus.start = 1'b1;
        @(posedge CLOCK_50); #1 bus.start = 1'b0;
        repeat (8000) @(posedge CLOCK_50);
        #1;
        check("abort_busy_pre", 32'(bus.busy), 1);
        check("abort_p1_pre", 32'(bus.p1_count), 50);
        resetn = 1'b0;
        #1;
        check("abort_addr", 32'(bus.ram_address), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_oc", 32'(bus.ordered_colours), 32'(OC_RESET));
        check_counts("abort", 0, 0, 0, 0);
        #4 resetn = 1'b1;
        @(posedge CLOCK_50); #1;
        check("abort_idle_busy", 32'(bus.busy), 0);

        // Fresh tally of the mixed map, with stray starts mid-sweep.
        run_tally("mixed", 1'b1, OC_RESET);
        check_counts("mixed", 50, 10, 100, 30);
        check("mixed_oc", 32'(bus.ordered_colours), 32'(OC_MIXED));

        // Restart from DONE with a new map; old ranking holds until new done.
        load_tie();
        run_tally("tie", 1'b0, OC_MIXED);
        check_counts("tie", 5, 200, 5, 200);
        check("tie_oc", 32'(bus.ordered_colours), 32'(OC_TIE));
        check("tie_done", 32'(bus.done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
